pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/pipe_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: hazard/branch/memory status in, stall/flush controls and counters out.
interface pipe_ctrl_if #(parameter int unsigned CNT_W = 16);
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_two_src;
  logic             exe_wb_en;
  logic [3:0]       exe_dest;
  logic             exe_mem_r_en;
  logic             mem_wb_en;
  logic [3:0]       mem_dest;
  logic             fwd_en;
  logic             branch_taken;
  logic             mem_req;
  logic             sram_ready;
  logic             freeze_pc;
  logic             flush_if_id;
  logic             bubble_id_ex;
  logic             freeze_all;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_src1, id_src2, id_two_src, exe_wb_en, exe_dest, exe_mem_r_en,
           mem_wb_en, mem_dest, fwd_en, branch_taken, mem_req, sram_ready,
    input  freeze_pc, flush_if_id, bubble_id_ex, freeze_all, mem_err,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, exe_wb_en, exe_dest, exe_mem_r_en,
           mem_wb_en, mem_dest, fwd_en, branch_taken, mem_req, sram_ready,
    output freeze_pc, flush_if_id, bubble_id_ex, freeze_all, mem_err,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush/SRAM-wait controller with sticky timeout flag and
// saturating stall/flush performance counters.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);
  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic m_exe, m_mem, hazard;
  logic frz_all, frz_pc, flush, bubble, pipe_ok;

  // Source match against EX/MEM destinations; forwarding leaves only load-use.
  always_comb begin
    m_exe = (bus.id_src1 == bus.exe_dest) ||
            (bus.id_two_src && (bus.id_src2 == bus.exe_dest));
    m_mem = (bus.id_src1 == bus.mem_dest) ||
            (bus.id_two_src && (bus.id_src2 == bus.mem_dest));
    if (bus.fwd_en) hazard = bus.exe_wb_en && bus.exe_mem_r_en && m_exe;
    else            hazard = (bus.exe_wb_en && m_exe) || (bus.mem_wb_en && m_mem);
  end

  // Next state and control; memory wait outranks branch flush outranks stall.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    mem_err_d = mem_err_q;
    frz_all   = 1'b0;
    frz_pc    = 1'b0;
    flush     = 1'b0;
    bubble    = 1'b0;
    pipe_ok   = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.mem_req && !bus.sram_ready) begin
          frz_all = 1'b1;
          state_d = MEM_WAIT;
          wcnt_d  = WCNT_W'(1);
        end else begin
          pipe_ok = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.sram_ready) begin
          state_d = RUN;
          wcnt_d  = '0;
          pipe_ok = 1'b1;
        end else if (wcnt_q < WCNT_W'(TIMEOUT)) begin
          frz_all = 1'b1;
          wcnt_d  = wcnt_q + WCNT_W'(1);
        end else begin
          mem_err_d = 1'b1;
          state_d   = RUN;
          wcnt_d    = '0;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
    if (pipe_ok) begin
      if (bus.branch_taken) begin
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (hazard) begin
        frz_pc = 1'b1;
        bubble = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((frz_all || frz_pc) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1))               flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are forced low while reset is held, whatever the inputs do.
  assign bus.freeze_all   = frz_all & rst_n;
  assign bus.freeze_pc    = frz_pc  & rst_n;
  assign bus.flush_if_id  = flush   & rst_n;
  assign bus.bubble_id_ex = bubble  & rst_n;
  assign bus.mem_err      = mem_err_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, branch flush, SRAM wait/timeout, async reset.
module tb_pipe_ctrl;
  localparam int unsigned CNT_W = 16;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   exp_stall;
  int   exp_flush;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bif ();

  pipe_ctrl #(.TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ctrl(input string tag, input logic fa, input logic fp, input logic fl, input logic bb);
    chk1({tag, ".freeze_all"},   bif.freeze_all,   fa);
    chk1({tag, ".freeze_pc"},    bif.freeze_pc,    fp);
    chk1({tag, ".flush_if_id"},  bif.flush_if_id,  fl);
    chk1({tag, ".bubble_id_ex"}, bif.bubble_id_ex, bb);
  endtask

  task automatic cnts(input string tag);
    chkn({tag, ".stall_cnt"}, bif.stall_cnt, CNT_W'(exp_stall));
    chkn({tag, ".flush_cnt"}, bif.flush_cnt, CNT_W'(exp_flush));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bif.id_src1 = 4'd0; bif.id_src2 = 4'd0; bif.id_two_src = 1'b0;
    bif.exe_wb_en = 1'b0; bif.exe_dest = 4'd0; bif.exe_mem_r_en = 1'b0;
    bif.mem_wb_en = 1'b0; bif.mem_dest = 4'd0; bif.fwd_en = 1'b0;
    bif.branch_taken = 1'b0; bif.mem_req = 1'b0; bif.sram_ready = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; exp_stall = 0; exp_flush = 0;
    clr();
    rst_n = 1'b0;
    bif.branch_taken = 1'b1;
    #2;
    ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cnts("reset");
    chk1("reset.mem_err", bif.mem_err, 1'b0);
    rst_n = 1'b1;
    clr();
    #1;
    ctrl("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // EX-destination hazard without forwarding
    bif.fwd_en = 1'b0; bif.exe_wb_en = 1'b1; bif.exe_dest = 4'd3; bif.id_src1 = 4'd3;
    #1;
    ctrl("exe_haz", 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); exp_stall = 1;
    cnts("exe_haz");

    // MEM-destination hazard via second source, then same with id_two_src low
    clr();
    bif.mem_wb_en = 1'b1; bif.mem_dest = 4'd7; bif.id_two_src = 1'b1; bif.id_src2 = 4'd7; bif.id_src1 = 4'd1;
    #1;
    ctrl("mem_haz", 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); exp_stall = 2;
    bif.id_two_src = 1'b0;
    #1;
    ctrl("mem_haz_one_src", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cnts("mem_haz_one_src");

    // Load-use with forwarding; plain ALU result forwards without stall
    clr();
    bif.fwd_en = 1'b1; bif.exe_mem_r_en = 1'b1; bif.exe_wb_en = 1'b1; bif.exe_dest = 4'd5;
    bif.id_two_src = 1'b1; bif.id_src2 = 4'd5; bif.id_src1 = 4'd2;
    bif.mem_wb_en = 1'b1; bif.mem_dest = 4'd2;
    #1;
    ctrl("load_use", 1'b0, 1'b1, 1'b0, 1'b1);
    tick(); exp_stall = 3;
    bif.exe_mem_r_en = 1'b0;
    #1;
    ctrl("fwd_no_stall", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    cnts("fwd_no_stall");

    // Branch beats a pending load-use hazard
    bif.exe_mem_r_en = 1'b1; bif.branch_taken = 1'b1;
    #1;
    ctrl("branch", 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); exp_flush = 1;
    cnts("branch");

    // SRAM wait: 4 frozen cycles, ready cycle releases and lets the branch through
    clr();
    bif.mem_req = 1'b1; bif.sram_ready = 1'b0; bif.branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      ctrl($sformatf("wait%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
      tick(); exp_stall++;
    end
    bif.sram_ready = 1'b1;
    #1;
    ctrl("wait_ready", 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); exp_flush = 2;
    cnts("wait_ready");
    clr();
    #1;
    ctrl("wait_back_run", 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("wait.mem_err", bif.mem_err, 1'b0);

    // SRAM never answers: 15 frozen cycles, then abort with sticky mem_err
    bif.mem_req = 1'b1; bif.sram_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      chk1($sformatf("to%0d.freeze_all", i), bif.freeze_all, 1'b1);
      tick(); exp_stall++;
    end
    #1;
    ctrl("to_abort", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk1("to.mem_err", bif.mem_err, 1'b1);
    cnts("to_abort");
    bif.mem_req = 1'b0;
    #1;
    ctrl("to_back_run", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk1("to.mem_err_sticky", bif.mem_err, 1'b1);

    // Async reset in the middle of a wait
    bif.mem_req = 1'b1;
    #1;
    chk1("pre_rst.freeze_all", bif.freeze_all, 1'b1);
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    exp_stall = 0; exp_flush = 0;
    ctrl("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    cnts("async_rst");
    chk1("async_rst.mem_err", bif.mem_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bif.mem_req = 1'b0;
    #1;
    ctrl("post_rst_run", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk1("post_rst.mem_err", bif.mem_err, 1'b0);
    cnts("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
